// File: rtl/riscv_pkg.sv
// Shared RISC-V constants: data width, register address width, opcodes and ALU ops.
package riscv_pkg;

    localparam int          XLEN       = 32;
    localparam int          REG_ADDR_W = 5;
    localparam logic [31:0] ZERO_32BIT = 32'h0000_0000;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of WB, long-latency unit, decode scoreboard and register-file write-port signals.
interface regfile_wb_arbiter_if #(parameter int XLEN = riscv_pkg::XLEN);
    import riscv_pkg::*;

    logic                  pipe_wr_en;
    logic [REG_ADDR_W-1:0] pipe_wr_addr;
    logic [XLEN-1:0]       pipe_wr_data;

    logic                  lu_valid;
    logic [REG_ADDR_W-1:0] lu_rd;
    logic [XLEN-1:0]       lu_data;
    logic                  lu_ready;

    logic                  issue_en;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  sb_stall;
    logic [31:0]           busy_mask;

    logic                  rf_wr_en;
    logic [REG_ADDR_W-1:0] rf_wr_addr;
    logic [XLEN-1:0]       rf_wr_data;

    modport slave (
        input  pipe_wr_en, pipe_wr_addr, pipe_wr_data,
        input  lu_valid, lu_rd, lu_data,
        output lu_ready,
        input  issue_en, issue_rd, id_rs1, id_rs2, id_rd,
        output sb_stall, busy_mask,
        output rf_wr_en, rf_wr_addr, rf_wr_data
    );

    modport master (
        output pipe_wr_en, pipe_wr_addr, pipe_wr_data,
        output lu_valid, lu_rd, lu_data,
        input  lu_ready,
        output issue_en, issue_rd, id_rs1, id_rs2, id_rd,
        input  sb_stall, busy_mask,
        input  rf_wr_en, rf_wr_addr, rf_wr_data
    );

endinterface

// File: rtl/wb_result_fifo.sv
// Circular FIFO buffering long-latency results ({addr, data}) until the write port is free.
module wb_result_fifo #(
    parameter int QDEPTH = 2,
    parameter int WIDTH  = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int             PW       = $clog2(QDEPTH);
    localparam logic [PW:0]    FULL_CNT = QDEPTH[PW:0];

    logic [WIDTH-1:0] mem [QDEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; count gates every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between WB and a long-latency unit, with a busy scoreboard.
// Optional REGFILE_WBARB_BYPASS_EN: stall ignores a register whose result drains this cycle.
module regfile_wb_arbiter
    import riscv_pkg::*;
#(
    parameter int QDEPTH = 2,
    parameter int XLEN   = riscv_pkg::XLEN
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int EW = REG_ADDR_W + XLEN;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [EW-1:0]         fifo_head;
    logic [REG_ADDR_W-1:0] head_addr;
    logic [XLEN-1:0]       head_data;
    logic                  lu_ready_w;
    logic                  lu_push;
    logic                  pipe_eff;
    logic                  drain;
    logic [31:0]           busy_q;
    logic [31:0]           busy_next;
    logic [31:0]           stall_mask;

    assign head_addr  = fifo_head[EW-1:XLEN];
    assign head_data  = fifo_head[XLEN-1:0];
    assign lu_ready_w = !fifo_full && !rst;
    assign lu_push    = bus.lu_valid && lu_ready_w && (bus.lu_rd != '0);
    assign pipe_eff   = bus.pipe_wr_en && (bus.pipe_wr_addr != '0) && !rst;
    assign drain      = !pipe_eff && !fifo_empty && !rst;

    wb_result_fifo #(
        .QDEPTH (QDEPTH),
        .WIDTH  (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (lu_push),
        .push_data ({bus.lu_rd, bus.lu_data}),
        .pop       (drain),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        bus.rf_wr_en   = 1'b0;
        bus.rf_wr_addr = '0;
        bus.rf_wr_data = '0;
        if (pipe_eff) begin
            bus.rf_wr_en   = 1'b1;
            bus.rf_wr_addr = bus.pipe_wr_addr;
            bus.rf_wr_data = bus.pipe_wr_data;
        end else if (drain) begin
            bus.rf_wr_en   = 1'b1;
            bus.rf_wr_addr = head_addr;
            bus.rf_wr_data = head_data;
        end
    end

    // Issue wins over a same-cycle drain of an older result to the same register.
    always_comb begin
        busy_next = busy_q;
        for (int r = 1; r < 32; r++) begin
            if (bus.issue_en && (bus.issue_rd == r[REG_ADDR_W-1:0]))
                busy_next[r] = 1'b1;
            else if (drain && (head_addr == r[REG_ADDR_W-1:0]))
                busy_next[r] = 1'b0;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_next;
    end

    always_comb begin
        stall_mask = busy_q;
`ifdef REGFILE_WBARB_BYPASS_EN
        if (drain) stall_mask[head_addr] = 1'b0;
`endif
        stall_mask[0] = 1'b0;
    end

    assign bus.sb_stall  = !rst && (stall_mask[bus.id_rs1] | stall_mask[bus.id_rs2] |
                                    stall_mask[bus.id_rd]);
    assign bus.busy_mask = busy_q;
    assign bus.lu_ready  = lu_ready_w;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected register writes queue, negedge monitor checks them.
module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    regfile_wb_arbiter_if #(.XLEN(32)) rf_if ();

    regfile_wb_arbiter #(.QDEPTH(2), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (rf_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        rf_if.pipe_wr_en   = 1'b0;
        rf_if.pipe_wr_addr = '0;
        rf_if.pipe_wr_data = '0;
        rf_if.lu_valid     = 1'b0;
        rf_if.lu_rd        = '0;
        rf_if.lu_data      = '0;
        rf_if.issue_en     = 1'b0;
        rf_if.issue_rd     = '0;
        rf_if.id_rs1       = '0;
        rf_if.id_rs2       = '0;
        rf_if.id_rd        = '0;
    endtask

    task automatic pipe(input logic [4:0] a, input logic [31:0] d);
        rf_if.pipe_wr_en   = 1'b1;
        rf_if.pipe_wr_addr = a;
        rf_if.pipe_wr_data = d;
        if (a != 5'd0) exp_q.push_back('{addr: a, data: d});
    endtask

    task automatic lu(input logic [4:0] a, input logic [31:0] d);
        rf_if.lu_valid = 1'b1;
        rf_if.lu_rd    = a;
        rf_if.lu_data  = d;
    endtask

    // Monitor: every write the DUT presents must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && rf_if.rf_wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rf_write", 64'({rf_if.rf_wr_addr, rf_if.rf_wr_data}), 64'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rf_write", 64'({rf_if.rf_wr_addr, rf_if.rf_wr_data}), 64'({e.addr, e.data}));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic exp_stall_drain;
`ifdef REGFILE_WBARB_BYPASS_EN
        exp_stall_drain = 1'b0;
`else
        exp_stall_drain = 1'b1;
`endif
        idle();
        rst = 1'b1;
        settle();
        check("rst_lu_ready", 64'(rf_if.lu_ready), 64'(0));
        check("rst_rf_wr_en", 64'(rf_if.rf_wr_en), 64'(0));
        tick();
        settle();
        check("rst_busy_mask", 64'(rf_if.busy_mask), 64'(0));
        check("rst_sb_stall", 64'(rf_if.sb_stall), 64'(0));
        check("rst_wr_addr", 64'(rf_if.rf_wr_addr), 64'(0));
        check("rst_wr_data", 64'(rf_if.rf_wr_data), 64'(0));
        tick();
        rst = 1'b0;
        settle();
        check("post_rst_lu_ready", 64'(rf_if.lu_ready), 64'(1));

        // Pipe pass-through.
        tick(); idle();
        pipe(5'd5, 32'hDEADBEEF);
        settle();
        check("pipe_wr_en", 64'(rf_if.rf_wr_en), 64'(1));
        check("pipe_busy_mask", 64'(rf_if.busy_mask), 64'(0));

        // Issue x7, stall on rs1, LU result, drain, release.
        tick(); idle();
        rf_if.issue_en = 1'b1; rf_if.issue_rd = 5'd7;
        tick(); idle();
        rf_if.id_rs1 = 5'd7;
        settle();
        check("x7_stall", 64'(rf_if.sb_stall), 64'(1));
        check("x7_busy", 64'(rf_if.busy_mask), 64'(32'h0000_0080));
        tick(); idle();
        rf_if.id_rs1 = 5'd7;
        lu(5'd7, 32'h1234);
        exp_q.push_back('{addr: 5'd7, data: 32'h1234});
        settle();
        check("x7_accept_ready", 64'(rf_if.lu_ready), 64'(1));
        check("x7_no_same_cycle_write", 64'(rf_if.rf_wr_en), 64'(0));
        tick(); idle();
        rf_if.id_rs1 = 5'd7;
        settle();
        check("x7_drain_wr_en", 64'(rf_if.rf_wr_en), 64'(1));
        check("x7_drain_stall", 64'(rf_if.sb_stall), 64'(exp_stall_drain));
        tick(); idle();
        rf_if.id_rs1 = 5'd7;
        settle();
        check("x7_released", 64'(rf_if.sb_stall), 64'(0));
        check("x7_busy_clear", 64'(rf_if.busy_mask), 64'(0));

        // Continuous pipe writes starve the buffer; back-pressure after 2 accepts.
        tick(); idle();
        pipe(5'd1, 32'h100); lu(5'd10, 32'hA0);
        settle(); check("bp_ready_0", 64'(rf_if.lu_ready), 64'(1));
        tick(); idle();
        pipe(5'd2, 32'h200); lu(5'd11, 32'hB0);
        settle(); check("bp_ready_1", 64'(rf_if.lu_ready), 64'(1));
        tick(); idle();
        pipe(5'd3, 32'h300); lu(5'd12, 32'hC0);
        settle(); check("bp_full_0", 64'(rf_if.lu_ready), 64'(0));
        tick(); idle();
        pipe(5'd4, 32'h400); lu(5'd12, 32'hC0);
        settle(); check("bp_full_1", 64'(rf_if.lu_ready), 64'(0));
        tick(); idle();
        lu(5'd12, 32'hC0);
        exp_q.push_back('{addr: 5'd10, data: 32'hA0});
        settle();
        check("bp_full_during_pop", 64'(rf_if.lu_ready), 64'(0));
        check("bp_drain0", 64'(rf_if.rf_wr_en), 64'(1));
        tick(); idle();
        lu(5'd12, 32'hC0);
        exp_q.push_back('{addr: 5'd11, data: 32'hB0});
        settle();
        check("bp_ready_after_pop", 64'(rf_if.lu_ready), 64'(1));
        tick(); idle();
        exp_q.push_back('{addr: 5'd12, data: 32'hC0});
        settle(); check("bp_drain2", 64'(rf_if.rf_wr_en), 64'(1));
        tick(); idle();
        settle(); check("bp_empty", 64'(rf_if.rf_wr_en), 64'(0));

        // Pipe write to x0 does not block a drain.
        tick(); idle();
        pipe(5'd6, 32'h600); lu(5'd13, 32'hD0);
        tick(); idle();
        pipe(5'd0, 32'hFFFF);
        exp_q.push_back('{addr: 5'd13, data: 32'hD0});
        settle();
        check("x0_drain_addr", 64'(rf_if.rf_wr_addr), 64'(13));
        tick(); idle();
        settle(); check("x0_empty", 64'(rf_if.rf_wr_en), 64'(0));

        // Same-cycle issue of x9 and drain of an older x9 result keeps busy set.
        tick(); idle();
        rf_if.issue_en = 1'b1; rf_if.issue_rd = 5'd9;
        tick(); idle();
        pipe(5'd2, 32'h222); lu(5'd9, 32'h99);
        tick(); idle();
        rf_if.issue_en = 1'b1; rf_if.issue_rd = 5'd9; rf_if.id_rs2 = 5'd9;
        exp_q.push_back('{addr: 5'd9, data: 32'h99});
        settle();
        check("x9_drain_stall", 64'(rf_if.sb_stall), 64'(exp_stall_drain));
        tick(); idle();
        rf_if.id_rs2 = 5'd9;
        settle();
        check("x9_busy_kept", 64'(rf_if.busy_mask), 64'(32'h0000_0200));
        check("x9_stall_kept", 64'(rf_if.sb_stall), 64'(1));
        tick(); idle();
        lu(5'd9, 32'h999);
        exp_q.push_back('{addr: 5'd9, data: 32'h999});
        tick(); idle();
        tick(); idle();
        settle(); check("x9_busy_clear", 64'(rf_if.busy_mask), 64'(0));

        // Reset with 2 buffered entries and busy bits set.
        tick(); idle();
        rf_if.issue_en = 1'b1; rf_if.issue_rd = 5'd20;
        tick(); idle();
        rf_if.issue_en = 1'b1; rf_if.issue_rd = 5'd21;
        tick(); idle();
        pipe(5'd3, 32'h333); lu(5'd20, 32'h2020);
        tick(); idle();
        pipe(5'd3, 32'h334); lu(5'd21, 32'h2121);
        tick(); idle();
        rst = 1'b1;
        rf_if.pipe_wr_en = 1'b1; rf_if.pipe_wr_addr = 5'd3; rf_if.pipe_wr_data = 32'h55;
        rf_if.id_rs1 = 5'd20;
        settle();
        check("mid_rst_busy_before_edge", 64'(rf_if.busy_mask), 64'(32'h0030_0000));
        check("mid_rst_wr_en", 64'(rf_if.rf_wr_en), 64'(0));
        check("mid_rst_stall", 64'(rf_if.sb_stall), 64'(0));
        check("mid_rst_lu_ready", 64'(rf_if.lu_ready), 64'(0));
        tick(); idle();
        rst = 1'b0;
        rf_if.id_rs1 = 5'd20;
        settle();
        check("post_mid_rst_busy", 64'(rf_if.busy_mask), 64'(0));
        check("post_mid_rst_wr_en", 64'(rf_if.rf_wr_en), 64'(0));
        check("post_mid_rst_ready", 64'(rf_if.lu_ready), 64'(1));
        check("post_mid_rst_stall", 64'(rf_if.sb_stall), 64'(0));

        tick(); idle();
        tick();
        tick();
        check("all_writes_seen", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
